mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
- Multi-precision add/subtract sequencer built around one instance of the team's 32-bit carry-lookahead adder (carry_lookahead_adder_32_bit).
- Captures two WORDS×32-bit operands and feeds them through the adder one 32-bit word per cycle, LSW first.
- Holds the inter-word carry in a register and returns the full-width result over a valid/ready handshake.
- Sits between the operand bus and the ALU result path for wide (128-bit default) arithmetic.

Parameters:
- WORDS, 4, number of 32-bit words per operand; legal range 1..16; operand width = 32*WORDS.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands/op present
- in_ready  out  1  block can accept a new operation
- op_a  in  32*WORDS  operand A
- op_b  in  32*WORDS  operand B
- op_sub  in  1  0 = A+B, 1 = A−B
- abort  in  1  synchronous cancel of a running operation
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- result  out  32*WORDS  sum/difference
- carry_out  out  1  final carry; for subtract, 1 = no borrow
- busy  out  1  high in RUN or DONE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - state=IDLE; result=0, carry_out=0, res_valid=0, busy=0, word index=0, carry register=0, captured operands=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all partial results; no res_valid is produced.
- States: IDLE, RUN, DONE (encoded 2 bits).
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture op_a, op_b (B bitwise inverted if op_sub), carry register = op_sub, idx=0; go to RUN.
  - Inputs may change freely after acceptance.
- RUN:
  - in_ready=0.
  - Each cycle, the adder sees A word[idx], B' word[idx], and the carry register.
  - On the edge: result word[idx] = adder sum, carry register = adder cout, idx += 1.
  - On the edge processing idx = WORDS−1: carry_out = adder cout; res_valid=1; go to DONE.
- Latency: res_valid rises exactly WORDS cycles after the accept edge.
  - WORDS=1: one RUN cycle.
- DONE:
  - result, carry_out, res_valid held stable until res_ready=1.
  - On res_valid & res_ready: res_valid=0; go to IDLE.
  - in_ready stays 0 in DONE, so no new accept in the handoff cycle; the earliest next accept is the cycle after.
- abort:
  - In RUN: next state IDLE; res_valid stays 0; result is not cleared (don't-care); carry register cleared.
  - Ignored in IDLE and DONE.
  - abort and rst together: rst wins (identical outcome).
- Index counter width: max(1, $clog2(WORDS)). No wrap-around is reachable; idx resets to 0 on every accept.
- Arithmetic: unsigned modulo 2^(32*WORDS). Carry propagates only through the registered carry; no combinational path from input ports to outputs.

Optional Feature:
- Macro MP_ADD_FLAGS_EN.
- When defined, adds two outputs, both registered and updated with result in the RUN→DONE edge, reset to 0, held in DONE:
  - zero_flag  out  1: result is all zeros.
  - ovf_flag  out  1: two's-complement signed overflow = carry into MSB XOR carry out of MSB of the top word. The carry into the MSB is recomputed as a[31]^b'[31]^sum[31] of the top word.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package mp_add_pkg:
  - WORD_W=32
  - state typedef mp_state_t {IDLE, RUN, DONE}
  - MAX_WORDS=16
- Sub-module: only the existing carry_lookahead_adder_32_bit instance. Word select/update stays in this module; no further sub-module.

Test Plan:
- Carry ripple: WORDS=4, A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, op_sub=0 → result=0x0000_0000_0000_0000_0000_0001_0000_0000, carry_out=0, res_valid exactly 4 cycles after accept.
- Full overflow: A=all ones, B=1 → result=0, carry_out=1; with MP_ADD_FLAGS_EN: zero_flag=1, ovf_flag=0.
- Subtract with borrow: A=5, B=7, op_sub=1 → result=0xFFFF…FFFE, carry_out=0.
- Subtract without borrow: A=7, B=5 → result=2, carry_out=1.
- Backpressure: hold res_ready=0 for 3 cycles in DONE → result/res_valid stable, in_ready=0. Raise res_ready → res_valid=0 next cycle; new in_valid accepted the following cycle.
- Abort/reset mid-run:
  - Assert abort when idx=2 → IDLE next cycle, res_valid never rises, in_ready=1. A following op A=3, B=4 gives result=7.
  - Repeat the same sequence with rst instead of abort → all outputs 0.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_t;

  // Word index width; a single-word operand still needs a one-bit counter.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder_32_bit.sv
// 32-bit two-level carry-lookahead adder: 4-bit groups with group generate/propagate.
module carry_lookahead_adder_32_bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  // Bit and group lookahead terms, then per-bit carries from the group carry-in
  always_comb begin
    logic [31:0] g_s;
    logic [31:0] p_s;
    logic [7:0]  gg_s;
    logic [7:0]  gp_s;
    logic [8:0]  gc_s;
    logic [32:0] c_s;
    g_s  = a_i & b_i;
    p_s  = a_i ^ b_i;
    gg_s = 8'd0;
    gp_s = 8'd0;
    gc_s = 9'd0;
    c_s  = 33'd0;
    for (int k = 0; k < 8; k++) begin
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
      gp_s[k] = &p_s[4*k +: 4];
    end
    gc_s[0] = cin_i;
    for (int k = 0; k < 8; k++) begin
      gc_s[k+1] = gg_s[k] | (gp_s[k] & gc_s[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c_s[4*k]   = gc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
    end
    c_s[32] = gc_s[8];
    sum_o   = p_s ^ c_s[31:0];
    cout_o  = c_s[32];
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision add/subtract over one 32-bit CLA, LSW first.
// Optional MP_ADD_FLAGS_EN adds registered zero_flag / ovf_flag outputs.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  op_sub,
  input  logic                  abort,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [32*WORDS-1:0]   result,
  output logic                  carry_out,
`ifdef MP_ADD_FLAGS_EN
  output logic                  zero_flag,
  output logic                  ovf_flag,
`endif
  output logic                  busy
);

  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  mp_state_t state_q, state_d;
  logic [IDX_W-1:0]              idx_q;
  logic [WORDS-1:0][WORD_W-1:0]  a_q;
  logic [WORDS-1:0][WORD_W-1:0]  b_q;
  logic [WORDS-1:0][WORD_W-1:0]  result_q;
  logic                          carry_q;
  logic                          carry_out_q;
  logic                          res_valid_q;

  logic [WORD_W-1:0] word_a_s;
  logic [WORD_W-1:0] word_b_s;
  logic [WORD_W-1:0] sum_s;
  logic              cout_s;
  logic              last_s;

  assign word_a_s = a_q[idx_q];
  assign word_b_s = b_q[idx_q];
  assign last_s   = (idx_q == LAST_IDX);

  carry_lookahead_adder_32_bit u_cla (
    .a_i    (word_a_s),
    .b_i    (word_b_s),
    .cin_i  (carry_q),
    .sum_o  (sum_s),
    .cout_o (cout_s)
  );

`ifdef MP_ADD_FLAGS_EN
  logic [WORDS-1:0][WORD_W-1:0] res_next_s;
  logic zero_flag_q;
  logic ovf_flag_q;
  logic msb_cin_s;

  // Full result as it will look after the final word is written
  always_comb begin
    res_next_s        = result_q;
    res_next_s[idx_q] = sum_s;
    msb_cin_s         = word_a_s[WORD_W-1] ^ word_b_s[WORD_W-1] ^ sum_s[WORD_W-1];
  end

  // Flags register alongside the final result word
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
    end else if ((state_q == RUN) && !abort && last_s) begin
      zero_flag_q <= ~|res_next_s;
      ovf_flag_q  <= msb_cin_s ^ cout_s;
    end
  end

  assign zero_flag = zero_flag_q;
  assign ovf_flag  = ovf_flag_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort only matters while words are being processed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
      RUN:     begin in_ready = 1'b0; busy = 1'b1; end
      DONE:    begin in_ready = 1'b0; busy = 1'b1; end
      default: begin in_ready = 1'b0; busy = 1'b0; end
    endcase
  end

  // Operand capture, per-word accumulation and result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1: the +1 rides in as the first carry
            a_q     <= op_a;
            b_q     <= op_sub ? ~op_b : op_b;
            carry_q <= op_sub;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            carry_q <= 1'b0;
          end else begin
            result_q[idx_q] <= sum_s;
            carry_q         <= cout_s;
            idx_q           <= idx_q + IDX_W'(1);
            if (last_s) begin
              carry_out_q <= cout_s;
              res_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed scoreboard bench for mp_add_sequencer (WORDS=4).
module tb_mp_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         abort;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         busy;
`ifdef MP_ADD_FLAGS_EN
  logic         zero_flag;
  logic         ovf_flag;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mp_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry_out (carry_out),
`ifdef MP_ADD_FLAGS_EN
    .zero_flag (zero_flag),
    .ovf_flag  (ovf_flag),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation and push its expected outcome; returns one cycle after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    exp_t         e;
    int           n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_before_accept", W'(in_ready), W'(1));
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    e.res  = full[W-1:0];
    e.cout = full[W];
    e.zero = (full[W-1:0] == '0);
    e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    sb_q.push_back(e);
    step();
    in_valid = 1'b0;
    op_a     = {$urandom(), $urandom(), $urandom(), $urandom()};
    op_b     = {$urandom(), $urandom(), $urandom(), $urandom()};
    op_sub   = ~sub;
    check("busy_in_run", W'(busy), W'(1));
    check("ready_low_in_run", W'(in_ready), W'(0));
  endtask

  // Wait for the result, check latency and value, hold in DONE, then hand off.
  task automatic collect(input int hold, input logic abort_in_done);
    int   lat;
    exp_t e;
    lat = 1;
    while (!res_valid && lat < 50) begin
      step();
      lat++;
    end
    // issue() already consumed the first post-accept cycle
    check("latency", W'(lat - 1), W'(WORDS));
    check("res_valid_up", W'(res_valid), W'(1));
    check("sb_not_empty", W'(sb_q.size() > 0), W'(1));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e = '0;
    end
    check("result", result, e.res);
    check("carry_out", W'(carry_out), W'(e.cout));
`ifdef MP_ADD_FLAGS_EN
    check("zero_flag", W'(zero_flag), W'(e.zero));
    check("ovf_flag", W'(ovf_flag), W'(e.ovf));
`endif
    for (int i = 0; i < hold; i++) begin
      abort = abort_in_done;
      step();
      check("hold_valid", W'(res_valid), W'(1));
      check("hold_result", result, e.res);
      check("hold_carry", W'(carry_out), W'(e.cout));
      check("hold_in_ready", W'(in_ready), W'(0));
    end
    abort     = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("handoff_valid", W'(res_valid), W'(0));
    check("handoff_in_ready", W'(in_ready), W'(1));
    check("handoff_busy", W'(busy), W'(0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;
    step();
    step();
    check("rst_result", result, '0);
    check("rst_carry", W'(carry_out), W'(0));
    check("rst_valid", W'(res_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    rst = 1'b0;
    step();
    check("post_rst_ready", W'(in_ready), W'(1));

    // Carry ripples from word 0 into word 1
    issue(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0);
    collect(0, 1'b0);
    // All-ones plus one wraps to zero with carry out
    issue({W{1'b1}}, 128'h1, 1'b0);
    collect(0, 1'b0);
    // Subtract with and without borrow
    issue(128'h5, 128'h7, 1'b1);
    collect(0, 1'b0);
    issue(128'h7, 128'h5, 1'b1);
    collect(0, 1'b0);
    // Backpressure for three cycles with abort asserted in DONE, then back-to-back accept
    issue({$urandom(), $urandom(), $urandom(), $urandom()},
          {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    collect(3, 1'b1);
    issue(128'h8000_0000_0000_0000_0000_0000_0000_0000,
          128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    collect(1, 1'b0);
    issue(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0);
    collect(0, 1'b0);

    // Abort with the word index at 2
    issue({W{1'b1}}, {W{1'b1}}, 1'b0);
    void'(sb_q.pop_back());
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", W'(res_valid), W'(0));
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_busy", W'(busy), W'(0));
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_valid", W'(res_valid), W'(0));
    end
    issue(128'h3, 128'h4, 1'b0);
    collect(0, 1'b0);

    // Same sequence with reset instead of abort
    issue({W{1'b1}}, {W{1'b1}}, 1'b0);
    void'(sb_q.pop_back());
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_result", result, '0);
    check("midrst_carry", W'(carry_out), W'(0));
    check("midrst_valid", W'(res_valid), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_valid", W'(res_valid), W'(0));
    end
    issue(128'h3, 128'h4, 1'b0);
    collect(0, 1'b0);

    check("sb_drained", W'(sb_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
